// File: rtl/i2s_tx.sv
// I2S master transmitter: serialises one stereo PCM pair per frame onto bck_o/lrck_o/data_o.
// Latency: a pair accepted during a frame is sent in the next frame; serial outputs are registered.
// Backpressure: single-entry holding register, s_ready low while full; an empty holding register at frame load sends zeros and pulses underrun.
module i2s_tx #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCK_DIV  = 2,
    parameter bit LEFT_LVL = 1'b0
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bck_o,
    output logic              lrck_o,
    output logic              data_o,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FW = 2 * SLOT_W;
    localparam int BW = $clog2(FW);
    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [BW-1:0] B_LAST   = BW'(FW - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

    logic [DW-1:0]     div_q, div_d;
    logic              bck_q, bck_d;
    logic [BW-1:0]     b_q, b_d;
    logic              lrck_q, lrck_d;
    logic              data_q, data_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              fs_q, fs_d;
    logic              ur_q, ur_d;
    logic              full_q, full_d;
    logic              ready_q;
    logic [DATA_W-1:0] hl_q, hl_d;
    logic [DATA_W-1:0] hr_q, hr_d;

    logic          tick;
    logic          fall;
    logic          load;
    logic          accept;
    logic [FW-1:0] load_frame;

    assign tick   = (div_q == DIV_LAST);
    // A bit period ends on the bck_o 1->0 transition; frame load is the one that wraps b.
    assign fall   = en & tick & bck_q;
    assign load   = fall & (b_q == B_LAST);
    assign accept = s_valid & ready_q;

    // Next frame image: left then right, each MSB-aligned in its slot, or silence on underrun.
    always_comb begin
        load_frame = '0;
        if (full_q) begin
            load_frame[FW-1 -: DATA_W]     = hl_q;
            load_frame[SLOT_W-1 -: DATA_W] = hr_q;
        end
    end

    // Serial side: divider, bit index, word select and one-BCK-delayed data shifting.
    always_comb begin
        div_d   = div_q;
        bck_d   = bck_q;
        b_d     = b_q;
        lrck_d  = lrck_q;
        data_d  = data_q;
        frame_d = frame_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        if (!en) begin
            div_d   = '0;
            bck_d   = 1'b0;
            b_d     = B_LAST;
            lrck_d  = ~LEFT_LVL;
            data_d  = 1'b0;
            frame_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                bck_d = ~bck_q;
            end
            if (fall) begin
                b_d     = load ? '0 : b_q + 1'b1;
                lrck_d  = (b_d < BW'(SLOT_W)) ? LEFT_LVL : ~LEFT_LVL;
                // The bit leaving the top is the one sent during the new bit period,
                // so the last bit of a frame is still on the wire during b=0.
                data_d  = frame_q[FW-1];
                frame_d = load ? load_frame : (frame_q << 1);
                fs_d    = load;
                ur_d    = load & ~full_q;
            end
        end
    end

    // Holding register: filled by the handshake, drained by a frame load; unaffected by en.
    always_comb begin
        full_d = full_q;
        hl_d   = hl_q;
        hr_d   = hr_q;
        if (load && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            hl_d   = l_data;
            hr_d   = r_data;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            div_q   <= '0;
            bck_q   <= 1'b0;
            b_q     <= B_LAST;
            lrck_q  <= ~LEFT_LVL;
            data_q  <= 1'b0;
            frame_q <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            hl_q    <= '0;
            hr_q    <= '0;
        end else begin
            div_q   <= div_d;
            bck_q   <= bck_d;
            b_q     <= b_d;
            lrck_q  <= lrck_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
            full_q  <= full_d;
            ready_q <= ~full_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
        end
    end

    assign s_ready     = ready_q;
    assign bck_o       = bck_q;
    assign lrck_o      = lrck_q;
    assign data_o      = data_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: serialises parallel left/right PCM samples onto BCK/LRCK/DATA.
- Other end of the I2S link to the existing I2S-to-DAC bridge. Used as the test-signal source and as a loopback/output path in the same audio design.
- Generates BCK by dividing sclk. Fetches one stereo sample pair per frame through a valid/ready handshake.

Parameters:
- DATA_W, 24, sample width in bits (two's complement, MSB first); must be <= SLOT_W
- SLOT_W, 32, BCK periods per channel slot; the frame is 2*SLOT_W BCK periods
- BCK_DIV, 2, sclk cycles per BCK half-period (>=1)
- LEFT_LVL, 0, LRCK level during the left slot

Ports:
- sclk, input, 1, master clock; all logic on its rising edge
- rstn, input, 1, synchronous active-low reset
- en, input, 1, run enable; low returns the serial side to its reset state
- l_data, input, DATA_W, left sample
- r_data, input, DATA_W, right sample
- s_valid, input, 1, sample pair present
- s_ready, output, 1, holding register empty
- bck_o, output, 1, bit clock
- lrck_o, output, 1, word select
- data_o, output, 1, serial data
- frame_start, output, 1, one-cycle pulse at frame load
- underrun, output, 1, one-cycle pulse when a frame is loaded with no sample pending

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock sclk.
- Reset values (rstn=0, or en=0): bck_o=0, lrck_o=~LEFT_LVL, data_o=0, frame_start=0, underrun=0, div counter=0, bit index b=2*SLOT_W-1.
- Reset only (not en=0): s_ready=1, holding register empty.
- en=0 leaves the holding register and handshake untouched.
- Handshake: transfer when s_valid&s_ready in a sclk cycle. l_data/r_data are captured into the holding register. s_ready is registered and equals ~full.
- Divider: div counts 0..BCK_DIV-1. At terminal count bck_o toggles and div wraps to 0. The first rising bck_o comes BCK_DIV cycles after en goes high out of reset.
- Falling edge (bck_o 1->0): b <= (b==2*SLOT_W-1) ? 0 : b+1. lrck_o and data_o update only in this cycle, so they are stable across each rising bck_o.
- lrck_o = LEFT_LVL for b in 0..SLOT_W-1, ~LEFT_LVL for b in SLOT_W..2*SLOT_W-1.
- Frame shift register is 2*SLOT_W bits, layout {l, zeros(SLOT_W-DATA_W), r, zeros}.
- data_o during bit b = frame bit b-1 (MSB first). This is the I2S one-BCK delay.
- During b=0, data_o = last bit of the previous frame (0 after reset).
- Load happens in the falling-edge cycle that enters b=0:
  - If holding is full: frame = holding, holding cleared, s_ready rises next cycle.
  - Otherwise: frame = all zeros and underrun pulses.
  - frame_start pulses in both cases.
- Same-cycle accept and load with holding empty: the frame is zeros (underrun), and the accepted pair goes into holding for the next frame.
- Holding register depth is 1; the source can fill it any time within the current frame.
- Reset or en=0 mid-frame: output is abandoned immediately (outputs reset next cycle). On restart, the first falling edge starts a fresh frame at b=0.
- Steady state: frame period = 4*SLOT_W*BCK_DIV sclk cycles; one pair consumed per frame.

Test Plan:
- Reset, en=1, no s_valid:
  - bck_o period = 4 sclk.
  - First falling edge at cycle 4 with frame_start=1 and underrun=1.
  - lrck_o goes 1->0 there; data_o stays 0 for all 64 bits.
- Push L=24'hA5A5A5, R=24'h123456 before first frame end:
  - Next frame: data_o bits b=1..24 = A5A5A5 MSB first, b=25..32 = 0.
  - b=33..56 = 123456, b=57..63 = 0.
  - lrck_o switches at b=32 while data_o still carries the left padding.
- Back-to-back stream of L=n, R=~n (n=1..4), s_valid held high:
  - s_ready low between loads; four frames, no underrun.
  - Each frame's bits match n and ~n.
- DATA_W=SLOT_W=32, L=32'h80000001, R=32'h00000001:
  - Left LSB at b=32; right MSB at b=33.
  - Right LSB appears at b=0 of the next frame.
- s_valid asserted in the exact load cycle with holding empty:
  - That frame is zeros with underrun=1.
  - The following frame carries the pair.
- Deassert en mid left slot (b=10):
  - Next cycle: bck_o=0, lrck_o=1, data_o=0.
  - Re-enable: frame_start after 4 cycles; the pending holding pair is transmitted intact.
